// File: rtl/signed_bcd_encoder_if.sv
// Handshake and digit-code bundle between the result register and the signed_bcd_encoder.
interface signed_bcd_encoder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             done;
    logic [3:0]       dig3;
    logic [3:0]       dig2;
    logic [3:0]       dig1;
    logic [3:0]       dig0;

    modport master (
        output start, value,
        input  busy, done, dig3, dig2, dig1, dig0
    );

    modport slave (
        input  start, value,
        output busy, done, dig3, dig2, dig1, dig0
    );
endinterface

// File: rtl/signed_bcd_encoder.sv
// Serial signed binary to sign + 3-digit BCD encoder (double dabble, one bit per clock).
// Optional LEADING_ZERO_BLANK_EN: blank leading zeros and float the minus sign rightwards.
module signed_bcd_encoder #(
    parameter int unsigned WIDTH = 8
) (
    input logic                 clk,
    input logic                 n_reset,
    signed_bcd_encoder_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [3:0] CodeMinus = 4'b1010;
    localparam logic [3:0] CodeBlank = 4'b1111;

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e           state_q;
    logic             neg_q;
    logic [WIDTH-1:0] mag_q;
    logic [11:0]      scratch_q;
    logic [CntW-1:0]  cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [3:0]       dig3_q, dig2_q, dig1_q, dig0_q;

    logic [WIDTH-1:0] value_abs;
    logic [11:0]      scratch_adj;
    logic [11:0]      scratch_shift;
    logic [3:0]       sign_code;
    logic [3:0]       disp3, disp2, disp1, disp0;

    // Unsigned magnitude: -2^(WIDTH-1) wraps to exactly 2^(WIDTH-1).
    always_comb begin
        value_abs = bus.value[WIDTH-1] ? (~bus.value + WIDTH'(1)) : bus.value;
    end

    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < 3; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        scratch_shift = {scratch_adj[10:0], mag_q[WIDTH-1]};
    end

    always_comb begin
        sign_code = neg_q ? CodeMinus : CodeBlank;
`ifdef LEADING_ZERO_BLANK_EN
        disp0 = scratch_q[3:0];
        if (scratch_q[11:8] != 4'd0) begin
            disp3 = sign_code;
            disp2 = scratch_q[11:8];
            disp1 = scratch_q[7:4];
        end else if (scratch_q[7:4] != 4'd0) begin
            disp3 = CodeBlank;
            disp2 = sign_code;
            disp1 = scratch_q[7:4];
        end else begin
            disp3 = CodeBlank;
            disp2 = CodeBlank;
            disp1 = sign_code;
        end
`else
        disp3 = sign_code;
        disp2 = scratch_q[11:8];
        disp1 = scratch_q[7:4];
        disp0 = scratch_q[3:0];
`endif
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= StIdle;
            neg_q     <= 1'b0;
            mag_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dig3_q    <= CodeBlank;
            dig2_q    <= CodeBlank;
            dig1_q    <= CodeBlank;
            dig0_q    <= CodeBlank;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        neg_q     <= bus.value[WIDTH-1];
                        mag_q     <= value_abs;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= StConv;
                    end
                end
                StConv: begin
                    scratch_q <= scratch_shift;
                    mag_q     <= mag_q << 1;
                    cnt_q     <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    dig3_q  <= disp3;
                    dig2_q  <= disp2;
                    dig1_q  <= disp1;
                    dig0_q  <= disp0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dig3 = dig3_q;
    assign bus.dig2 = dig2_q;
    assign bus.dig1 = dig1_q;
    assign bus.dig0 = dig0_q;
endmodule
